voting_seq: RTL and testbench

Sequential, parametrised successor to the combinational plurality voter. Ballots arrive one per cycle over a valid/ready stream into per-candidate saturating tally counters. On a close request the block scans the tallies one candidate per cycle to find the winner, then holds the result on a valid/ready output until it is taken. It serves flows that stream an unbounded ballot count instead of presenting all votes in parallel, and it adds abstention, tie reporting and saturation.

---
 rtl/voting_seq_if.sv | 37 +++
 rtl/voting_seq.sv | 169 ++++++++++++++++
 tb/tb_voting_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voting_seq_if.sv
// ---------------------------------------------------------------------------
// voting_seq_if
// Purpose : ballot input stream, close request and result output stream of
//           the sequential plurality voter, bundled into one interface.
// Signals : in_valid/in_ready/in_vote/in_abstain  ballot stream (one per cycle)
//           close                                 end-of-election request
//           out_valid/out_ready                   result handshake
//           out_winner/out_count/out_tie/out_ballots  result payload
// Modports: master  - ballot producer / result consumer
//           slave   - the voter itself
// ---------------------------------------------------------------------------
interface voting_seq_if #(
  parameter int N = 2,
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vote;
  logic         in_abstain;
  logic         close;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_winner;
  logic [W-1:0] out_count;
  logic         out_tie;
  logic [W-1:0] out_ballots;

  modport master (
    output in_valid, in_vote, in_abstain, close, out_ready,
    input  in_ready, out_valid, out_winner, out_count, out_tie, out_ballots
  );

  modport slave (
    input  in_valid, in_vote, in_abstain, close, out_ready,
    output in_ready, out_valid, out_winner, out_count, out_tie, out_ballots
  );
endinterface

// File: rtl/voting_seq.sv
// ---------------------------------------------------------------------------
// voting_seq
// Purpose : sequential plurality voter. Ballots stream in one per cycle and
//           bump per-candidate saturating tallies; a close request starts a
//           one-candidate-per-cycle scan for the winner, and the result is
//           held on a valid/ready output until taken.
// Params  : N  candidate index width (2**N candidates, N >= 1)
//           W  tally / ballot counter width
// Ports   : clk  rising-edge clock
//           rst  synchronous active-high reset
//           bus  voting_seq_if.slave (ballot stream, close, result stream)
// ---------------------------------------------------------------------------
module voting_seq #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  voting_seq_if.slave  bus
);

  localparam int            NC       = 2 ** N;
  localparam logic [W-1:0]  CNT_MAX  = {W{1'b1}};
  localparam logic [N-1:0]  IDX_LAST = {N{1'b1}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;

  logic [W-1:0] r_tally [NC];
  logic [W-1:0] r_ballots;
  logic [N-1:0] r_scan_idx;
  logic [W-1:0] r_best;
  logic [N-1:0] r_winner;
  logic         r_tie;
  logic         r_out_valid;

  logic         w_in_ready;
  logic         w_accept;
  logic         w_take;
  logic [NC-1:0] w_inc;
  logic [W-1:0] w_scan_tally;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (bus.close)                 w_state_next = SCAN;
      SCAN:    if (r_scan_idx == IDX_LAST)    w_state_next = RESULT;
      RESULT:  if (bus.out_ready)             w_state_next = COLLECT;
      default:                                w_state_next = COLLECT;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. in_ready is gated by rst so a ballot offered during reset
  // is never handshaken.
  // -------------------------------------------------------------------------
  always_comb begin
    w_in_ready = 1'b0;
    w_take     = 1'b0;
    case (r_state)
      COLLECT: w_in_ready = !rst;
      RESULT:  w_take     = bus.out_ready;
      default: ;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;

  // -------------------------------------------------------------------------
  // Tallies: one increment enable per candidate, suppressed at saturation.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_inc
      assign w_inc[gi] = w_accept && !bus.in_abstain &&
                         (bus.in_vote == N'(gi)) &&
                         (r_tally[gi] != CNT_MAX);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || w_take) begin
      for (int i = 0; i < NC; i++) begin
        r_tally[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (w_inc[i]) begin
          r_tally[i] <= r_tally[i] + W'(1);
        end
      end
    end
  end

  // Accepted-ballot counter, abstentions included, saturating.
  always_ff @(posedge clk) begin
    if (rst || w_take) begin
      r_ballots <= '0;
    end else if (w_accept && (r_ballots != CNT_MAX)) begin
      r_ballots <= r_ballots + W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Scan: one candidate per cycle. Strict '>' keeps the lowest index on a
  // tie; a later strictly larger tally clears any earlier tie flag. The index
  // wraps back to 0 after the last candidate, ready for the next election.
  // -------------------------------------------------------------------------
  assign w_scan_tally = r_tally[r_scan_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_idx <= '0;
      r_best     <= '0;
      r_winner   <= '0;
      r_tie      <= 1'b0;
    end else if (r_state == SCAN) begin
      r_scan_idx <= r_scan_idx + N'(1);
      if (r_scan_idx == '0) begin
        r_best   <= w_scan_tally;
        r_winner <= '0;
        r_tie    <= 1'b0;
      end else if (w_scan_tally > r_best) begin
        r_best   <= w_scan_tally;
        r_winner <= r_scan_idx;
        r_tie    <= 1'b0;
      end else if (w_scan_tally == r_best) begin
        r_tie    <= 1'b1;
      end
    end
  end

  // out_valid registered straight from the next-state decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == RESULT);
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_winner  = r_winner;
  assign bus.out_count   = r_best;
  assign bus.out_tie     = r_tie;
  assign bus.out_ballots = r_ballots;

endmodule

// File: tb/tb_voting_seq.sv
// ---------------------------------------------------------------------------
// tb_voting_seq
// Purpose : self-checking bench for voting_seq (N=2, W=4). A behavioural
//           election model (unbounded integer tallies, saturation applied
//           only when judging) is compared against the DUT every cycle, and
//           each election result is also compared with a hand-computed value.
// ---------------------------------------------------------------------------
module tb_voting_seq;

  localparam int N   = 2;
  localparam int W   = 4;
  localparam int NC  = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  voting_seq_if #(.N(N), .W(W)) vif ();

  voting_seq #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  typedef struct {
    int winner;
    int count;
    int tie;
    int ballots;
  } res_t;

  res_t lit_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: 0 = collecting, 1 = scanning, 2 = result held
  int   m_phase     = 0;
  int   m_scan_left = 0;
  int   m_tally [NC] = '{default: 0};
  int   m_ballots   = 0;
  res_t m_res       = '{0, 0, 0, 0};
  int   edge_n      = 0;

  // Compare-process bookkeeping
  logic rst_prev   = 1'b1;
  int   prev_phase = 0;
  int   close_neg  = 0;
  int   h_winner   = 0;
  int   h_count    = 0;
  int   h_tie      = 0;
  int   h_ballots  = 0;
  bit   done       = 1'b0;
  bit   final_done = 1'b0;

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Plurality with lowest-index tie-break, from saturated tallies.
  function automatic res_t judge(input int t [NC], input int b);
    res_t r;
    int   best;
    int   n_best;
    best     = -1;
    r.winner = 0;
    for (int i = 0; i < NC; i++) begin
      if (sat(t[i]) > best) begin
        best     = sat(t[i]);
        r.winner = i;
      end
    end
    n_best = 0;
    for (int i = 0; i < NC; i++) begin
      if (sat(t[i]) == best) n_best++;
    end
    r.count   = best;
    r.tie     = (n_best > 1) ? 1 : 0;
    r.ballots = sat(b);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Model update on the active edge
  // -------------------------------------------------------------------------
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (rst) begin
      m_phase   <= 0;
      m_ballots <= 0;
      for (int i = 0; i < NC; i++) m_tally[i] <= 0;
    end else begin
      case (m_phase)
        0: begin
          if (vif.in_valid) begin
            m_ballots <= m_ballots + 1;
            if (!vif.in_abstain) m_tally[vif.in_vote] <= m_tally[vif.in_vote] + 1;
          end
          if (vif.close) begin
            m_phase     <= 1;
            m_scan_left <= NC;
          end
        end
        1: begin
          m_scan_left <= m_scan_left - 1;
          if (m_scan_left == 1) begin
            m_phase <= 2;
            m_res   <= judge(m_tally, m_ballots);
          end
        end
        default: begin
          if (vif.out_ready) begin
            m_phase   <= 0;
            m_ballots <= 0;
            for (int i = 0; i < NC; i++) m_tally[i] <= 0;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Compare process, on the inactive edge
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    if (edge_n >= 1) begin
      chk("in_ready",    int'(vif.in_ready),    (m_phase == 0 && !rst) ? 1 : 0);
      chk("out_valid",   int'(vif.out_valid),   (m_phase == 2) ? 1 : 0);
      chk("out_ballots", int'(vif.out_ballots), sat(m_ballots));
      if (m_phase == 2) begin
        chk("out_winner", int'(vif.out_winner), m_res.winner);
        chk("out_count",  int'(vif.out_count),  m_res.count);
        chk("out_tie",    int'(vif.out_tie),    m_res.tie);
      end

      if (rst_prev && !rst) begin
        chk("rst_out_valid",   int'(vif.out_valid),   0);
        chk("rst_out_winner",  int'(vif.out_winner),  0);
        chk("rst_out_count",   int'(vif.out_count),   0);
        chk("rst_out_tie",     int'(vif.out_tie),     0);
        chk("rst_out_ballots", int'(vif.out_ballots), 0);
        chk("rst_in_ready",    int'(vif.in_ready),    1);
      end

      if (m_phase == 0 && !rst && vif.close) close_neg <= edge_n;

      if (m_phase == 2 && prev_phase != 2) begin
        chk("latency", edge_n - close_neg, NC + 1);
        if (lit_q.size() > 0) begin
          res_t lit;
          lit = lit_q.pop_front();
          $display("[TB] election: winner=%0d count=%0d tie=%0d ballots=%0d (expect %0d/%0d/%0d/%0d)",
                   vif.out_winner, vif.out_count, vif.out_tie, vif.out_ballots,
                   lit.winner, lit.count, lit.tie, lit.ballots);
          chk("lit_winner",  int'(vif.out_winner),  lit.winner);
          chk("lit_count",   int'(vif.out_count),   lit.count);
          chk("lit_tie",     int'(vif.out_tie),     lit.tie);
          chk("lit_ballots", int'(vif.out_ballots), lit.ballots);
        end else begin
          chk("lit_available", 0, 1);
        end
      end

      if (m_phase == 2 && prev_phase == 2) begin
        chk("hold_winner",  int'(vif.out_winner),  h_winner);
        chk("hold_count",   int'(vif.out_count),   h_count);
        chk("hold_tie",     int'(vif.out_tie),     h_tie);
        chk("hold_ballots", int'(vif.out_ballots), h_ballots);
      end
    end

    if (done && !final_done) begin
      chk("lit_q_empty", lit_q.size(), 0);
      final_done <= 1'b1;
    end

    rst_prev   <= rst;
    prev_phase <= m_phase;
    h_winner   <= int'(vif.out_winner);
    h_count    <= int'(vif.out_count);
    h_tie      <= int'(vif.out_tie);
    h_ballots  <= int'(vif.out_ballots);
  end

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit ab, input bit cl);
    vif.in_valid   = 1'b1;
    vif.in_vote    = 2'(v);
    vif.in_abstain = ab;
    vif.close      = cl;
    step();
    vif.in_valid   = 1'b0;
    vif.in_abstain = 1'b0;
    vif.close      = 1'b0;
  endtask

  task automatic close_only();
    vif.close = 1'b1;
    step();
    vif.close = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 40 && m_phase != ph; i++) step();
  endtask

  task automatic push_lit(input int w, input int c, input int t, input int b);
    res_t r;
    r.winner  = w;
    r.count   = c;
    r.tie     = t;
    r.ballots = b;
    lit_q.push_back(r);
  endtask

  initial begin
    vif.in_valid   = 1'b0;
    vif.in_vote    = '0;
    vif.in_abstain = 1'b0;
    vif.close      = 1'b0;
    vif.out_ready  = 1'b1;

    // Reset held for two cycles
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Plurality
    push_lit(2, 3, 0, 5);
    send(2, 0, 0); send(2, 0, 0); send(1, 0, 0); send(3, 0, 0); send(2, 0, 0);
    close_only();
    wait_phase(2);
    wait_phase(0);
    step();

    // Tie and abstain, close with the last ballot
    push_lit(1, 2, 1, 5);
    send(3, 0, 0); send(1, 0, 0); send(3, 0, 0); send(1, 0, 0);
    send(0, 1, 1);
    wait_phase(2);
    wait_phase(0);
    step();

    // Saturation
    push_lit(0, 15, 0, 15);
    for (int i = 0; i < 20; i++) send(0, 0, 0);
    close_only();
    wait_phase(2);
    wait_phase(0);
    step();

    // Back-pressure in RESULT, then re-arm
    vif.out_ready = 1'b0;
    push_lit(2, 1, 0, 1);
    send(2, 0, 0);
    close_only();
    wait_phase(2);
    vif.in_valid = 1'b1;
    vif.in_vote  = 2'd1;
    vif.close    = 1'b1;
    for (int i = 0; i < 10; i++) step();
    vif.in_valid  = 1'b0;
    vif.close     = 1'b0;
    vif.out_ready = 1'b1;
    step();
    push_lit(3, 1, 0, 1);
    send(3, 0, 0);
    close_only();
    wait_phase(2);
    wait_phase(0);
    step();

    // Reset in the second SCAN cycle, then an empty election
    send(1, 0, 0);
    close_only();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    push_lit(0, 0, 1, 0);
    close_only();
    wait_phase(2);
    wait_phase(0);
    step();

    done = 1'b1;
    for (int i = 0; i < 5 && !final_done; i++) step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
